// File: rtl/graphic_instruction_queue.sv
// Double-buffered capture queue for CPU graphic instructions: the CPU fills the back bank,
// the rasteriser reads the front bank, and the two banks swap at end-of-frame.
module graphic_instruction_queue #(
    parameter int unsigned     INS_W        = 32,
    parameter int unsigned     DEPTH        = 64,
    parameter int unsigned     ADD_W        = 6,
    parameter int unsigned     COORD_W      = 10,
    parameter int unsigned     X_LAST       = 634,
    parameter int unsigned     Y_LAST       = 479,
    parameter int unsigned     CAPTURE_MODE = 0,
    parameter int unsigned     HOLD_EMPTY   = 1,
    parameter logic [INS_W-1:0] NOP         = '0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [COORD_W-1:0] SYS_X,
    input  logic [COORD_W-1:0] SYS_Y,
    input  logic [INS_W-1:0]   INS,
    input  logic               INS_VALID,
    input  logic [ADD_W-1:0]   RD_ADD,
    output logic [INS_W-1:0]   RD_INS,
    output logic [ADD_W:0]     FRONT_COUNT,
    output logic               BANK_SEL,
    output logic               FRAME_SWAP,
    output logic               OVERFLOW
);

    localparam int unsigned CNT_W  = ADD_W + 1;
    localparam int unsigned MEM_AW = ADD_W + 1;

    // Both banks share one RAM; the top address bit selects the bank.
    logic [INS_W-1:0] mem [2*DEPTH];

    logic [CNT_W-1:0] back_cnt_q,   back_cnt_d;
    logic [CNT_W-1:0] front_cnt_q,  front_cnt_d;
    logic             bank_sel_q,   bank_sel_d;
    logic             frame_swap_q, frame_swap_d;
    logic             overflow_q,   overflow_d;
    logic             eof_prev_q;
    logic [INS_W-1:0] last_q,       last_d;
    logic [INS_W-1:0] rd_ins_q,     rd_ins_d;

    logic              eof_raw_c, eof_c, wr_req_c, swap_c, full_c, wr_en_c;
    logic [CNT_W-1:0]  base_cnt_c;
    logic [MEM_AW-1:0] wr_addr_c;
    logic [MEM_AW-1:0] rd_addr_c;

    assign eof_raw_c = (SYS_X == COORD_W'(X_LAST)) && (SYS_Y == COORD_W'(Y_LAST));
    assign rd_addr_c = {bank_sel_q, RD_ADD};

    // Swap resolves before the write, so a same-cycle write lands at slot 0 of the new back bank.
    always_comb begin
        back_cnt_d   = back_cnt_q;
        front_cnt_d  = front_cnt_q;
        bank_sel_d   = bank_sel_q;
        frame_swap_d = 1'b0;
        overflow_d   = overflow_q;
        last_d       = last_q;
        rd_ins_d     = NOP;

        eof_c = eof_raw_c && !eof_prev_q;
        if (CAPTURE_MODE != 0) begin
            wr_req_c = INS_VALID && (INS != NOP);
        end else begin
            wr_req_c = (INS != NOP) && (INS != last_q);
        end
        swap_c = eof_c && ((back_cnt_q != '0) || (HOLD_EMPTY == 0));

        base_cnt_c = swap_c ? '0 : back_cnt_q;
        full_c     = (base_cnt_c == CNT_W'(DEPTH));
        wr_en_c    = wr_req_c && !full_c;
        wr_addr_c  = {(swap_c ? bank_sel_q : ~bank_sel_q), base_cnt_c[ADD_W-1:0]};

        if (swap_c) begin
            bank_sel_d   = ~bank_sel_q;
            front_cnt_d  = back_cnt_q;
            overflow_d   = 1'b0;
            frame_swap_d = 1'b1;
        end
        if (wr_req_c) begin
            last_d = INS;
            if (full_c) begin
                overflow_d = 1'b1;
            end
        end
        back_cnt_d = base_cnt_c + CNT_W'(wr_en_c);

        if ({1'b0, RD_ADD} < front_cnt_q) begin
            rd_ins_d = mem[rd_addr_c];
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en_c) begin
            mem[wr_addr_c] <= INS;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            back_cnt_q   <= '0;
            front_cnt_q  <= '0;
            bank_sel_q   <= 1'b0;
            frame_swap_q <= 1'b0;
            overflow_q   <= 1'b0;
            eof_prev_q   <= 1'b0;
            last_q       <= NOP;
            rd_ins_q     <= NOP;
        end else begin
            back_cnt_q   <= back_cnt_d;
            front_cnt_q  <= front_cnt_d;
            bank_sel_q   <= bank_sel_d;
            frame_swap_q <= frame_swap_d;
            overflow_q   <= overflow_d;
            eof_prev_q   <= eof_raw_c;
            last_q       <= last_d;
            rd_ins_q     <= rd_ins_d;
        end
    end

    assign RD_INS      = rd_ins_q;
    assign FRONT_COUNT = front_cnt_q;
    assign BANK_SEL    = bank_sel_q;
    assign FRAME_SWAP  = frame_swap_q;
    assign OVERFLOW    = overflow_q;

endmodule

// File: tb/tb_graphic_instruction_queue.sv
// Bench for graphic_instruction_queue: three configurations (mode0/hold, mode0/no-hold, mode1/hold)
// share one stimulus stream and are each compared against a queue-based frame model.
module tb_graphic_instruction_queue;

    localparam int N     = 3;
    localparam int DEPTH = 64;
    typedef logic [31:0] word_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [9:0]  SYS_X, SYS_Y;
    word_t       INS;
    logic        INS_VALID;
    logic [5:0]  RD_ADD;

    word_t       rd_ins [N];
    logic [6:0]  fc     [N];
    logic        bank   [N];
    logic        fs     [N];
    logic        ovf    [N];

    always #5 CLK = ~CLK;

    graphic_instruction_queue #(.CAPTURE_MODE(0), .HOLD_EMPTY(1)) u_m0h1 (
        .CLK(CLK), .RST(RST), .SYS_X(SYS_X), .SYS_Y(SYS_Y), .INS(INS), .INS_VALID(INS_VALID),
        .RD_ADD(RD_ADD), .RD_INS(rd_ins[0]), .FRONT_COUNT(fc[0]), .BANK_SEL(bank[0]),
        .FRAME_SWAP(fs[0]), .OVERFLOW(ovf[0]));
    graphic_instruction_queue #(.CAPTURE_MODE(0), .HOLD_EMPTY(0)) u_m0h0 (
        .CLK(CLK), .RST(RST), .SYS_X(SYS_X), .SYS_Y(SYS_Y), .INS(INS), .INS_VALID(INS_VALID),
        .RD_ADD(RD_ADD), .RD_INS(rd_ins[1]), .FRONT_COUNT(fc[1]), .BANK_SEL(bank[1]),
        .FRAME_SWAP(fs[1]), .OVERFLOW(ovf[1]));
    graphic_instruction_queue #(.CAPTURE_MODE(1), .HOLD_EMPTY(1)) u_m1h1 (
        .CLK(CLK), .RST(RST), .SYS_X(SYS_X), .SYS_Y(SYS_Y), .INS(INS), .INS_VALID(INS_VALID),
        .RD_ADD(RD_ADD), .RD_INS(rd_ins[2]), .FRONT_COUNT(fc[2]), .BANK_SEL(bank[2]),
        .FRAME_SWAP(fs[2]), .OVERFLOW(ovf[2]));

    int checks   = 0;
    int failures = 0;

    // Frame-level model: the back bank is a list of captured words, the front bank a snapshot.
    word_t m_back  [N][$];
    word_t m_front [N][$];
    bit    m_bank  [N];
    bit    m_ovf   [N];
    bit    m_fs    [N];
    bit    m_eofp  [N];
    word_t m_last  [N];
    word_t m_rd    [N];

    function automatic bit is_mode1(int k);
        return k == 2;
    endfunction

    function automatic bit holds(int k);
        return k != 1;
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d actual=%0h required=%0h @%0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_back[k].delete();
            m_front[k].delete();
            m_bank[k] = 0; m_ovf[k] = 0; m_fs[k] = 0; m_eofp[k] = 0;
            m_last[k] = '0; m_rd[k] = '0;
        end
    endtask

    task automatic model_step();
        bit raw;
        raw = (SYS_X == 10'd634) && (SYS_Y == 10'd479);
        for (int k = 0; k < N; k++) begin
            bit eof, req;
            eof = raw && !m_eofp[k];
            m_eofp[k] = raw;
            req = is_mode1(k) ? (INS_VALID && INS != 0) : (INS != 0 && INS != m_last[k]);
            m_rd[k] = (int'(RD_ADD) < m_front[k].size()) ? m_front[k][RD_ADD] : '0;
            m_fs[k] = 0;
            if (eof && (m_back[k].size() > 0 || !holds(k))) begin
                m_front[k] = m_back[k];
                m_back[k].delete();
                m_bank[k] = ~m_bank[k];
                m_ovf[k]  = 0;
                m_fs[k]   = 1;
            end
            if (req) begin
                if (m_back[k].size() == DEPTH) m_ovf[k] = 1;
                else m_back[k].push_back(INS);
                m_last[k] = INS;
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < N; k++) begin
            chk("rd_ins",      k, 64'(rd_ins[k]), 64'(m_rd[k]));
            chk("front_count", k, 64'(fc[k]),     64'(m_front[k].size()));
            chk("bank_sel",    k, 64'(bank[k]),   64'(m_bank[k]));
            chk("frame_swap",  k, 64'(fs[k]),     64'(m_fs[k]));
            chk("overflow",    k, 64'(ovf[k]),    64'(m_ovf[k]));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        check_model();
    endtask

    task automatic set_eof(input bit on);
        SYS_X = on ? 10'd634 : 10'd0;
        SYS_Y = on ? 10'd479 : 10'd0;
    endtask

    // Async reset asserted between clock edges; outputs must clear without a clock.
    task automatic async_reset();
        RST = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < N; k++) begin
            chk("rst_rd_ins", k, 64'(rd_ins[k]), 64'd0);
            chk("rst_fc",     k, 64'(fc[k]),     64'd0);
            chk("rst_bank",   k, 64'(bank[k]),   64'd0);
            chk("rst_fs",     k, 64'(fs[k]),     64'd0);
            chk("rst_ovf",    k, 64'(ovf[k]),    64'd0);
        end
        INS = '0;
        RST = 1'b1;
    endtask

    typedef struct {
        word_t      ins;
        bit         eof;
        logic [5:0] rd;
        logic [6:0] e_fc;
        bit         e_fs;
        word_t      e_rd;
    } vec_t;

    vec_t tv [11];
    int   nfs;
    int   dwell;

    initial begin
        RST = 1'b0; INS = '0; INS_VALID = 1'b0; RD_ADD = '0; set_eof(0);
        model_reset();
        @(posedge CLK); #1;
        async_reset();

        // Mode 0 capture: duplicates and NOP skipped, then swap and reads.
        tv[0]  = '{32'h11, 0, 6'd0, 7'd0, 0, 32'h0};
        tv[1]  = '{32'h11, 0, 6'd0, 7'd0, 0, 32'h0};
        tv[2]  = '{32'h22, 0, 6'd0, 7'd0, 0, 32'h0};
        tv[3]  = '{32'h00, 0, 6'd0, 7'd0, 0, 32'h0};
        tv[4]  = '{32'h22, 0, 6'd0, 7'd0, 0, 32'h0};
        tv[5]  = '{32'h33, 0, 6'd0, 7'd0, 0, 32'h0};
        tv[6]  = '{32'h33, 1, 6'd0, 7'd3, 1, 32'h0};
        tv[7]  = '{32'h33, 0, 6'd0, 7'd3, 0, 32'h11};
        tv[8]  = '{32'h33, 0, 6'd1, 7'd3, 0, 32'h22};
        tv[9]  = '{32'h33, 0, 6'd2, 7'd3, 0, 32'h33};
        tv[10] = '{32'h33, 0, 6'd3, 7'd3, 0, 32'h0};
        for (int i = 0; i < 11; i++) begin
            INS = tv[i].ins; INS_VALID = 1'b0; RD_ADD = tv[i].rd; set_eof(tv[i].eof);
            tick();
            chk("tbl_fc", i, 64'(fc[0]),     64'(tv[i].e_fc));
            chk("tbl_fs", i, 64'(fs[0]),     64'(tv[i].e_fs));
            chk("tbl_rd", i, 64'(rd_ins[0]), 64'(tv[i].e_rd));
        end

        // Dwell on the last pixel: exactly one swap.
        RD_ADD = '0;
        INS = 32'h44; tick();
        INS = 32'h55; tick();
        nfs = 0;
        set_eof(1);
        for (int i = 0; i < 10; i++) begin
            tick();
            nfs += int'(fs[0]);
        end
        chk("dwell_swaps", 0, 64'(nfs), 64'd1);
        chk("dwell_bank",  0, 64'(bank[0]), 64'd0);
        chk("dwell_fc",    0, 64'(fc[0]), 64'd2);
        set_eof(0); tick();

        // Overflow: DEPTH+2 distinct writes.
        for (int i = 0; i < DEPTH + 2; i++) begin
            INS = 32'h100 + 32'(i);
            tick();
        end
        chk("ovf_before", 0, 64'(ovf[0]), 64'd1);
        set_eof(1); tick();
        chk("ovf_fc",    0, 64'(fc[0]),  64'd64);
        chk("ovf_after", 0, 64'(ovf[0]), 64'd0);
        set_eof(0); RD_ADD = 6'd63; tick();
        chk("ovf_entry63", 0, 64'(rd_ins[0]), 64'h13F);
        RD_ADD = '0;

        // Empty frame: hold keeps front, no-hold swaps in an empty bank.
        INS = 32'h77; tick();
        set_eof(1); tick();
        chk("hold_fc1", 0, 64'(fc[0]), 64'd1);
        chk("hold_fc1", 1, 64'(fc[1]), 64'd1);
        set_eof(0); tick();
        set_eof(1); tick();
        chk("hold_fc",   0, 64'(fc[0]), 64'd1);
        chk("hold_fs",   0, 64'(fs[0]), 64'd0);
        chk("nohold_fc", 1, 64'(fc[1]), 64'd0);
        chk("nohold_fs", 1, 64'(fs[1]), 64'd1);
        set_eof(0); tick();

        // Mode 1: repeated strobes accepted; third strobe coincides with eof.
        INS = 32'hAA;
        INS_VALID = 1'b1; tick();
        INS_VALID = 1'b0; tick();
        INS_VALID = 1'b1; tick();
        INS_VALID = 1'b0; tick();
        INS_VALID = 1'b1; set_eof(1); tick();
        chk("m1_fc2", 2, 64'(fc[2]), 64'd2);
        chk("m1_fs",  2, 64'(fs[2]), 64'd1);
        INS_VALID = 1'b0; set_eof(0); tick();
        set_eof(1); tick();
        chk("m1_fc1", 2, 64'(fc[2]), 64'd1);
        set_eof(0); RD_ADD = '0; tick();
        chk("m1_rd0", 2, 64'(rd_ins[2]), 64'hAA);

        // Reset mid-frame with 5 entries queued.
        for (int i = 0; i < 5; i++) begin
            INS = 32'h501 + 32'(i);
            tick();
        end
        async_reset();
        set_eof(1); tick();
        chk("postrst_fc", 0, 64'(fc[0]), 64'd0);
        chk("postrst_fc", 1, 64'(fc[1]), 64'd0);
        set_eof(0); tick();

        // Randomised traffic against the model.
        dwell = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) INS = $urandom();
            else INS = 32'($urandom_range(0, 3));
            INS_VALID = 1'($urandom_range(0, 1));
            RD_ADD = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            if (dwell > 0) begin
                set_eof(1);
                dwell--;
            end else if ($urandom_range(0, 119) == 0) begin
                set_eof(1);
                dwell = $urandom_range(0, 3);
            end else begin
                SYS_X = ($urandom_range(0, 1) == 1) ? 10'd634 : 10'($urandom_range(0, 1023));
                SYS_Y = 10'($urandom_range(0, 1023));
            end
            if (i == 2000) async_reset();
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/graphic_instruction_queue.md
Name: graphic_instruction_queue

Overview:
Double-buffered capture queue for 32-bit graphic instructions from the CPU side. New instructions are written into a back bank during a frame. At end-of-frame the back and front banks swap, so the rasteriser always reads a complete instruction list and never sees a half-written one. This block generalises the single-bank graphic instruction control path: frame geometry, depth and width are parametrised, and it adds a selectable capture mode, full/overflow handling and a random-access read port.

Parameters:
INS_W, 32, instruction word width
DEPTH, 64, entries per bank (power of 2)
ADD_W, 6, log2(DEPTH)
COORD_W, 10, SYS_X/SYS_Y width
X_LAST, 634, SYS_X value marking end of frame
Y_LAST, 479, SYS_Y value marking end of frame
CAPTURE_MODE, 0, 0 = change-detect on INS; 1 = explicit INS_VALID strobe
HOLD_EMPTY, 1, 1 = skip the swap when the back bank is empty at end-of-frame
NOP, 0, instruction value treated as "no instruction"

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous reset, active-low
SYS_X  input  COORD_W  current raster X
SYS_Y  input  COORD_W  current raster Y
INS  input  INS_W  instruction word from CPU
INS_VALID  input  1  write strobe; used only when CAPTURE_MODE=1
RD_ADD  input  ADD_W  front-bank read address
RD_INS  output  INS_W  front-bank read data
FRONT_COUNT  output  ADD_W+1  number of valid entries in the front bank
BANK_SEL  output  1  index of the current front bank
FRAME_SWAP  output  1  one-cycle pulse, asserted the cycle after a swap
OVERFLOW  output  1  sticky: a write was dropped because the back bank was full

Behaviour:
- Reset (RST=0, asynchronous):
  - RD_INS=NOP, FRONT_COUNT=0, BANK_SEL=0, FRAME_SWAP=0, OVERFLOW=0.
  - Back write pointer/count = 0; last-captured register = NOP; eof_prev = 0.
  - Memory contents are don't-care; counts gate all reads.
- Write request (wr_req):
  - CAPTURE_MODE=0: INS != NOP and INS != last-captured.
  - CAPTURE_MODE=1: INS_VALID=1 and INS != NOP. Repeated values are accepted.
- Accepted write:
  - back[back_count] <= INS; back_count++; last-captured <= INS.
  - Each write is written exactly once.
- Full: when back_count == DEPTH, the write is dropped and OVERFLOW <= 1.
  - In mode 0, last-captured still updates, so the dropped value is not retried.
- End-of-frame (eof):
  - eof_raw = (SYS_X==X_LAST && SYS_Y==Y_LAST). eof = eof_raw && !eof_prev, one pulse per frame even if the raster dwells on that pixel for many clocks.
  - eof_prev is registered every cycle.
- Swap: on eof, if back_count>0 or HOLD_EMPTY=0:
  - BANK_SEL toggles; FRONT_COUNT <= back_count; back_count <= 0; OVERFLOW <= 0; FRAME_SWAP=1 next cycle.
  - If back_count==0 and HOLD_EMPTY=1: no swap, front retained (static scene persists), FRAME_SWAP stays 0.
- eof and wr_req in the same cycle:
  - The swap takes effect first.
  - The write goes to address 0 of the new back bank, and back_count becomes 1 (not back_count+1).
  - The write is never lost and never lands in the new front bank.
- last-captured is not cleared on swap. An unchanged INS in mode 0 is not re-captured in the next frame.
- Read port:
  - RD_INS <= (RD_ADD < FRONT_COUNT) ? front[RD_ADD] : NOP. One-cycle registered latency.
  - A read issued in the swap cycle returns data from the old front bank. Reads issued from the next cycle onward use the new front bank.
- Storage: 2*DEPTH words total, inferred as RAM. Write port serves the back bank; read port serves the front bank. No read/write collision is possible because the banks are distinct.
- Reset mid-frame: all counts clear immediately, and the next frame starts with an empty front bank.

Test Plan:
- Mode 0: drive INS=0x11, 0x11, 0x22, 0x00, 0x22, 0x33, then eof -> FRONT_COUNT=3; RD_ADD 0/1/2 -> 0x11/0x22/0x33 one cycle later; RD_ADD=3 -> NOP; FRAME_SWAP pulses once.
- Hold SYS_X=634, SYS_Y=479 for 10 clocks with 2 entries queued -> exactly one swap, BANK_SEL toggles once.
- Write DEPTH+2 distinct instructions, then eof -> FRONT_COUNT=64, OVERFLOW=1 before the swap and 0 after it; entry 63 = the 64th instruction.
- Queue 1 entry, eof; then eof again with no writes; HOLD_EMPTY=1 -> FRONT_COUNT stays 1, no second swap. With HOLD_EMPTY=0 -> FRONT_COUNT=0.
- Mode 1: INS_VALID pulses with 0xAA three times, the third coinciding with eof -> FRONT_COUNT=2; after the next eof FRONT_COUNT=1 with entry 0 = 0xAA.
- Assert RST low with 5 entries queued mid-frame -> all outputs reset asynchronously; after release and eof with no writes, FRONT_COUNT=0.
